psp_rvfi_tracer: RTL and testbench

Retirement trace capture stage that sits directly downstream of the `psp` core's RVFI output, alongside the RVFI monitor. Every retired instruction is stamped with a 64-bit retirement order number and checked for PC continuity. The resulting record is buffered in a small FIFO and drained over a valid/ready stream, which feeds a debug UART or a bench scoreboard. Overflow never stalls the core: records are dropped and counted instead.

---
 rtl/psp_trace_pkg.sv | 24 ++
 rtl/psp_rvfi_tracer_if.sv | 36 +++
 rtl/psp_trace_fifo.sv | 55 +++++
 rtl/psp_rvfi_tracer.sv | 116 +++++++++++
 tb/tb_psp_rvfi_tracer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psp_trace_pkg.sv
// Shared types for the psp retirement tracer. Defining PSP_TRACE_MEM_EN
// extends the trace record with the RVFI memory fields.
package psp_trace_pkg;

    localparam int ORDER_W = 64;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [31:0]        insn;
        logic [31:0]        pc;
        logic [31:0]        next_pc;
        logic [4:0]         rd_addr;
        logic [31:0]        rd_wdata;
        logic               pc_break;
`ifdef PSP_TRACE_MEM_EN
        logic [31:0]        mem_addr;
        logic [3:0]         mem_rmask;
        logic [3:0]         mem_wmask;
        logic [31:0]        mem_rdata;
        logic [31:0]        mem_wdata;
`endif
    } trace_rec_t;

endpackage

// File: rtl/psp_rvfi_tracer_if.sv
// RVFI retirement inputs plus the trace record output stream.
// master = core/consumer side, slave = tracer.
interface psp_rvfi_tracer_if;
    import psp_trace_pkg::*;

    logic        rvfi_valid;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_mem_wdata;

    logic        out_valid;
    logic        out_ready;
    trace_rec_t  out_rec;

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
        input  out_valid, out_rec
    );

    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
        output out_valid, out_rec
    );

endinterface

// File: rtl/psp_trace_fifo.sv
// Generic synchronous FIFO with extra-bit pointers; push is accepted when
// full only if a pop happens in the same cycle. clear beats push and pop.
module psp_trace_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    // Storage is left unreset; the output is masked while empty instead.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/psp_rvfi_tracer.sv
// Retirement trace capture: order stamping, PC continuity check, drop
// accounting and record buffering. PSP_TRACE_MEM_EN adds memory fields.
module psp_rvfi_tracer
    import psp_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    psp_rvfi_tracer_if.slave       tr,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [ORDER_W-1:0] order_q;
    logic [31:0]        last_npc;
    logic               last_npc_vld;
    trace_rec_t         rec_p0;
    logic               vld_p0;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;

`ifdef PSP_TRACE_MEM_EN
    logic mem_act;
    assign mem_act = (tr.rvfi_mem_rmask != 4'd0) || (tr.rvfi_mem_wmask != 4'd0);
`else
    logic unused_mem;
    assign unused_mem = ^{tr.rvfi_mem_addr, tr.rvfi_mem_rmask, tr.rvfi_mem_wmask,
                          tr.rvfi_mem_rdata, tr.rvfi_mem_wdata};
`endif

    // Stage p0: record formed combinationally from the retiring instruction
    always_comb begin
        rec_p0          = '0;
        rec_p0.order    = order_q;
        rec_p0.insn     = tr.rvfi_insn;
        rec_p0.pc       = tr.rvfi_pc_rdata;
        rec_p0.next_pc  = tr.rvfi_pc_wdata;
        rec_p0.rd_addr  = tr.rvfi_rd_addr;
        rec_p0.rd_wdata = (tr.rvfi_rd_addr == 5'd0) ? 32'd0 : tr.rvfi_rd_wdata;
        rec_p0.pc_break = last_npc_vld && (tr.rvfi_pc_rdata != last_npc);
`ifdef PSP_TRACE_MEM_EN
        if (mem_act) begin
            rec_p0.mem_addr  = tr.rvfi_mem_addr;
            rec_p0.mem_rmask = tr.rvfi_mem_rmask;
            rec_p0.mem_wmask = tr.rvfi_mem_wmask;
            rec_p0.mem_rdata = tr.rvfi_mem_rdata;
            rec_p0.mem_wdata = tr.rvfi_mem_wdata;
        end
`endif
    end

    assign vld_p0        = tr.rvfi_valid && enable && !clear;
    assign tr.out_valid  = !fifo_empty;
    assign pop           = tr.out_valid && tr.out_ready;
    assign drop          = vld_p0 && fifo_full && !pop;

    // Order and continuity track every retirement, captured or not, so that
    // drops and disabled periods remain visible as order gaps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            order_q      <= '0;
            last_npc_vld <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else if (clear) begin
            order_q      <= '0;
            last_npc_vld <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (tr.rvfi_valid) begin
                order_q      <= order_q + ORDER_W'(1);
                last_npc_vld <= 1'b1;
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tr.rvfi_valid) begin
            last_npc <= tr.rvfi_pc_wdata;
        end
    end

    // Stage p1: buffered records drained over the valid/ready stream
    psp_trace_fifo #(
        .T     (trace_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (vld_p0),
        .din     (rec_p0),
        .pop     (tr.out_ready),
        .dout    (tr.out_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_psp_rvfi_tracer.sv
// Self-checking bench for psp_rvfi_tracer: directed scenarios plus a random
// stream compared against a queue-based model of the retirement trace.
module tb_psp_rvfi_tracer;
    import psp_trace_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic                   clk;
    logic                   reset_n;
    logic                   clear;
    logic                   enable;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_count;

    psp_rvfi_tracer_if tif ();

    psp_rvfi_tracer #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .enable     (enable),
        .tr         (tif.slave),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk;
    int n_fail;

    trace_rec_t      mq[$];
    longint unsigned m_order;
    logic [31:0]     m_npc;
    bit              m_npc_vld;
    bit              m_ovf;
    int              m_drops;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_order   = 0;
        m_npc_vld = 0;
        m_ovf     = 0;
        m_drops   = 0;
    endtask

    task automatic model_step();
        trace_rec_t e;
        bit popd;
        bit pushd;
        if (clear) begin
            model_reset();
            return;
        end
        popd  = (mq.size() != 0) && tif.out_ready;
        pushd = 0;
        e     = '0;
        if (tif.rvfi_valid) begin
            e.order    = m_order;
            e.insn     = tif.rvfi_insn;
            e.pc       = tif.rvfi_pc_rdata;
            e.next_pc  = tif.rvfi_pc_wdata;
            e.rd_addr  = tif.rvfi_rd_addr;
            e.rd_wdata = (tif.rvfi_rd_addr == 0) ? 32'd0 : tif.rvfi_rd_wdata;
            e.pc_break = m_npc_vld && (tif.rvfi_pc_rdata != m_npc);
`ifdef PSP_TRACE_MEM_EN
            if (tif.rvfi_mem_rmask != 0 || tif.rvfi_mem_wmask != 0) begin
                e.mem_addr  = tif.rvfi_mem_addr;
                e.mem_rmask = tif.rvfi_mem_rmask;
                e.mem_wmask = tif.rvfi_mem_wmask;
                e.mem_rdata = tif.rvfi_mem_rdata;
                e.mem_wdata = tif.rvfi_mem_wdata;
            end
`endif
            if (enable) begin
                if (mq.size() < DEPTH || popd) pushd = 1;
                else begin
                    m_ovf = 1;
                    if (m_drops < (2**DROP_W) - 1) m_drops++;
                end
            end
            m_order++;
            m_npc     = tif.rvfi_pc_wdata;
            m_npc_vld = 1;
        end
        if (popd)  void'(mq.pop_front());
        if (pushd) mq.push_back(e);
    endtask

    task automatic compare_all();
        chk("out_valid", tif.out_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        if (mq.size() != 0) chk("out_rec", tif.out_rec, mq[0]);
    endtask

    // One clock: drive inputs, advance model at the edge, check 1ns later.
    task automatic step(input bit v, input bit en, input bit rdy, input bit clr,
                        input logic [31:0] pc, input logic [31:0] npc);
        tif.rvfi_valid     = v;
        tif.rvfi_insn      = $urandom;
        tif.rvfi_pc_rdata  = pc;
        tif.rvfi_pc_wdata  = npc;
        tif.rvfi_rd_addr   = 5'($urandom_range(0, 31));
        tif.rvfi_rd_wdata  = $urandom;
        tif.rvfi_mem_addr  = $urandom;
        tif.rvfi_mem_rmask = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        tif.rvfi_mem_wmask = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        tif.rvfi_mem_rdata = $urandom;
        tif.rvfi_mem_wdata = $urandom;
        tif.out_ready      = rdy;
        enable             = en;
        clear              = clr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #2;
        model_reset();
        chk("rst_out_valid", tif.out_valid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_out_rec", tif.out_rec, 0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] npc;
        int rdy_pct;
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        reset_n = 1'b0;
        clear   = 1'b0;
        enable  = 1'b0;
        tif.rvfi_valid = 1'b0;
        tif.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_pulse();

        // Basic stream
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 32'(4 * i), 32'(4 * i + 4));
            chk("basic_order", tif.out_rec.order, i);
            chk("basic_break", tif.out_rec.pc_break, 1'b0);
        end

        // Jump break, then no break after clear
        step(1, 1, 1, 0, 32'h10, 32'h14);
        step(1, 1, 1, 0, 32'h40, 32'h44);
        chk("jump_break", tif.out_rec.pc_break, 1'b1);
        step(0, 1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 32'h100, 32'h104);
        chk("clear_nobreak", tif.out_rec.pc_break, 1'b0);
        chk("clear_order0", tif.out_rec.order, 0);

        // Overflow and drain
        step(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 32'(4 * i), 32'(4 * i + 4));
        chk("ovf_level", level, DEPTH);
        chk("ovf_drops", drop_count, 4);
        chk("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", tif.out_rec.order, i);
            step(0, 1, 1, 0, 0, 0);
        end
        chk("drain_empty", tif.out_valid, 1'b0);

        // Full plus pop
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 32'(4 * i), 32'(4 * i + 4));
        step(1, 1, 1, 0, 32'h40, 32'h44);
        chk("fullpop_level", level, DEPTH);
        chk("fullpop_drops", drop_count, 0);

        // Enable gap
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, (i < 2 || i == 4), 0, 0, 32'(4 * i), 32'(4 * i + 4));
        chk("gap_order0", tif.out_rec.order, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("gap_order1", tif.out_rec.order, 1);
        step(0, 1, 1, 0, 0, 0);
        chk("gap_order4", tif.out_rec.order, 4);
        step(0, 1, 1, 0, 0, 0);

        // Clear with records buffered; a retirement in the clear cycle is lost
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'(4 * i), 32'(4 * i + 4));
        step(1, 1, 1, 1, 32'h14, 32'h18);
        chk("clr_valid", tif.out_valid, 1'b0);
        step(1, 1, 0, 0, 32'h18, 32'h1c);
        chk("clr_next_order", tif.out_rec.order, 0);

        // Same via reset
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'(4 * i), 32'(4 * i + 4));
        reset_pulse();
        step(1, 1, 0, 0, 32'h80, 32'h84);
        chk("rst_next_order", tif.out_rec.order, 0);
        chk("rst_next_break", tif.out_rec.pc_break, 1'b0);

        // Random stream
        npc     = 32'h1000;
        rdy_pct = 50;
        for (int i = 0; i < 1500; i++) begin
            bit v;
            if (i % 100 == 0) rdy_pct = 50 * $urandom_range(0, 2);
            v  = ($urandom_range(0, 9) < 7);
            pc = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hffff_fffc) : npc;
            if (v) npc = ($urandom_range(0, 5) == 0) ? ($urandom & 32'hffff_fffc) : pc + 32'd4;
            step(v, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < rdy_pct),
                 ($urandom_range(0, 99) == 0), pc, v ? npc : $urandom);
            if ($urandom_range(0, 499) == 0) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
